bcd_seven_seg_scanner: RTL

- Downstream consumer of the 2-digit binary-to-BCD converter: takes its 8-bit packed BCD word {tens, ones} and drives a time-multiplexed 2-digit seven-segment display.
- Captures new values through a load strobe and commits them only at frame boundaries, so the display never shows a mix of old and new digits.
- Applies leading-zero blanking, shows a dash for invalid nibbles, and inserts a one-cycle all-off gap between digits to prevent ghosting.

---
 rtl/bcd_seven_seg_scanner_if.sv | 22 ++
 rtl/bcd_seven_seg_scanner.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bcd_seven_seg_scanner_if.sv
// Bus between a BCD producer and the two-digit seven-segment scanner.
// master = producer side (drives value/strobe), slave = scanner side.
interface bcd_seven_seg_scanner_if;
  logic [7:0] bcd_in;
  logic       load;
  logic [6:0] seg;
  logic [1:0] an;
  logic       update_done;
  logic       dropped;
  logic       frame_tick;
  logic       err;

  modport master (
    output bcd_in, load,
    input  seg, an, update_done, dropped, frame_tick, err
  );

  modport slave (
    input  bcd_in, load,
    output seg, an, update_done, dropped, frame_tick, err
  );
endinterface

// File: rtl/bcd_seven_seg_scanner.sv
// Two-digit time-multiplexed seven-segment scanner.
// New values are staged in a pending register and committed only on entry
// to the tens slot, so a frame never mixes old and new digits. A one-cycle
// dark gap follows each digit slot to avoid ghosting.
module bcd_seven_seg_scanner #(
  parameter int CLK_DIV            = 4,
  parameter int BLANK_LEADING_ZERO = 1,
  parameter int ACTIVE_LOW         = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_seven_seg_scanner_if.slave   bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {OFF, TENS, GAP_T, ONES, GAP_O} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    pend, disp;
  logic          pend_vld;
  logic          upd_q, drop_q, err_q;
  logic          commit;
  logic [1:0]    an_raw;
  logic [6:0]    seg_raw;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction

  // Next-state: OFF waits for the first pending value, then the scan loops forever.
  always_comb begin
    state_nxt = state;
    case (state)
      OFF:     if (pend_vld) state_nxt = TENS;
      TENS:    if (cnt == LAST) state_nxt = GAP_T;
      GAP_T:   state_nxt = ONES;
      ONES:    if (cnt == LAST) state_nxt = GAP_O;
      GAP_O:   state_nxt = TENS;
      default: state_nxt = OFF;
    endcase
  end

  // Commit only at a frame boundary (entry into TENS from OFF or GAP_O).
  assign commit = (state_nxt == TENS) && (state != TENS) && pend_vld;

  // State register and slot counter; counter restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || (state != TENS && state != ONES))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  // Pending/display registers. A load coinciding with a commit becomes the
  // next pending value while the commit takes the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      disp     <= '0;
      upd_q    <= 1'b0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      upd_q  <= commit;
      drop_q <= bus.load && pend_vld && !commit;
      if (bus.load) begin
        pend     <= bus.bcd_in;
        pend_vld <= 1'b1;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end
      if (commit) begin
        disp  <= pend;
        err_q <= (pend[7:4] > 4'd9) || (pend[3:0] > 4'd9);
      end
    end
  end

  // Digit drive from registered state only; gaps and OFF stay dark.
  always_comb begin
    an_raw  = 2'b00;
    seg_raw = 7'h00;
    case (state)
      TENS: if (!(BLANK_LEADING_ZERO != 0 && disp[7:4] == 4'd0)) begin
        an_raw  = 2'b10;
        seg_raw = dec(disp[7:4]);
      end
      ONES: begin
        an_raw  = 2'b01;
        seg_raw = dec(disp[3:0]);
      end
      default: ;
    endcase
  end

  assign bus.seg         = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign bus.an          = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
  assign bus.update_done = upd_q;
  assign bus.dropped     = drop_q;
  assign bus.frame_tick  = (state == GAP_O);
  assign bus.err         = err_q;

endmodule
